// File: rtl/bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq
//
// Sequential BCD-to-binary converter using reverse double-dabble. The whole
// {bcd, bin} register is shifted right one bit per clock. After each shift,
// 3 is subtracted from every BCD digit that has reached 8 or more. After
// BIN_W shifts the binary field holds the value of the BCD input.
//
// This is the inverse of the binary-to-BCD path that drives the HEX
// displays. It turns switch-entered decimal digits back into a binary operand.
//
// Optional feature (macro BCD_TO_BIN_CHECK_EN):
//   defined     - a start carrying any digit above 9 skips conversion. The
//                 block goes straight to DONE with err=1 and bin_out=0.
//   not defined - no validity check. Invalid digits go through the same
//                 algorithm (deterministic result), and err is tied to 0.
//
// Parameters:
//   NUM_DIGITS - number of BCD digits on bcd_in (4 bits each)
//   BIN_W      - width of bin_out; must satisfy 2^BIN_W >= 10^NUM_DIGITS
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   start   in   conversion request, sampled on the rising clk edge
//   bcd_in  in   packed BCD, digit 0 (ones) in bits [3:0]
//   busy    out  high while a conversion is in progress
//   done    out  one-cycle pulse; bin_out/err were just updated
//   bin_out out  converted value, held until the next result
//   err     out  invalid digit flagged on the last conversion
//
// Handshake: start is honoured only while idle (busy=0 and done=0). bcd_in
// is captured on that same edge. Any start seen while busy or done is
// dropped, not queued. done is high for exactly one cycle per accepted
// start, unless a reset aborts the conversion. bin_out/err change only on
// the edge that raises done, or on reset. The FSM state is fully visible
// on busy/done: IDLE = 00, CONV = 10, DONE = 01.
// ---------------------------------------------------------------------------
module bcd_to_binary_seq #(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_W      = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;

  // The iteration counter starts at 0, so the BIN_W-th shift happens when
  // the counter reads BIN_W-1.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [SR_W-1:0]  sr;        // {bcd digits, binary result}
  logic [SR_W-1:0]  sr_shift;  // sr shifted right by one, MSB filled with 0
  logic [SR_W-1:0]  sr_step;   // sr_shift after the per-digit correction
  logic [CNT_W-1:0] iter_cnt;
  logic             last_iter;
  logic             bcd_invalid;

  assign last_iter = (iter_cnt == LAST_ITER);
  assign busy      = (state == S_CONV);
  assign done      = (state == S_DONE);

  // One reverse double-dabble step. A digit of 8 or more after the shift
  // means a 1 was shifted in from the next-higher digit. That 1 is worth 10
  // there but was counted as 8 here. Subtracting 3 corrects this, because
  // halving turns the 16/2 = 8 into the 10/2 = 5 it should be. Only the
  // digit MSB needs testing: a digit is at most 7 before the 1 arrives, so
  // 8 or more after the shift always has its MSB set.
  always_comb begin
    sr_shift = {1'b0, sr[SR_W-1:1]};
    sr_step  = sr_shift;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (sr_shift[BIN_W + 4*d + 3]) begin
        sr_step[BIN_W + 4*d +: 4] = sr_shift[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD_TO_BIN_CHECK_EN
  logic err_q;

  always_comb begin
    bcd_invalid = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        bcd_invalid = 1'b1;
      end
    end
  end

  // err shares the update points of bin_out. It is set when an invalid
  // start is rejected and cleared when a real conversion completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && start && bcd_invalid) begin
      err_q <= 1'b1;
    end else if (state == S_CONV && last_iter) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  // With no check, every start is converted, and err stays 0.
  assign bcd_invalid = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      sr       <= '0;
      iter_cnt <= '0;
      bin_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (bcd_invalid) begin
              // Rejected input: report right away, and never raise busy.
              bin_out <= '0;
              state   <= S_DONE;
            end else begin
              sr       <= {bcd_in, {BIN_W{1'b0}}};
              iter_cnt <= '0;
              state    <= S_CONV;
            end
          end
        end

        S_CONV: begin
          sr       <= sr_step;
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (last_iter) begin
            // Take the result from this step's value. The registered sr
            // is one shift behind at this edge.
            bin_out <= sr_step[BIN_W-1:0];
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Sequential BCD-to-binary converter. It uses reverse double-dabble: shift right one bit per clock, then subtract 3 from every BCD digit that is 8 or more.
It is the inverse of the combinational binary-to-BCD path that drives the HEX displays. It turns switch-entered decimal digits (SW grouped as BCD nibbles) back into a binary operand for counters and arithmetic blocks.
Start/busy/done handshake; one conversion in flight at a time.

Parameters:
NUM_DIGITS, 3, number of BCD digits at input (4 bits each)
BIN_W, 10, output binary width; must satisfy 2^BIN_W >= 10^NUM_DIGITS

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  conversion request, sampled on rising clk edge
bcd_in  input  4*NUM_DIGITS  packed BCD; digit 0 (ones) in bits [3:0]
busy  output  1  high while conversion in progress
done  output  1  one-cycle pulse: bin_out/err valid and updated
bin_out  output  BIN_W  converted value, held until next accepted start
err  output  1  invalid BCD digit flagged on last conversion; held with bin_out

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset (async, any state incl. mid-conversion):
  - state=IDLE; busy=0; done=0; bin_out=0; err=0.
  - Shift register and iteration counter cleared.
  - The aborted conversion produces no done pulse.
- FSM states: IDLE, CONV, DONE (registered, one-hot or binary at implementer's choice).
- IDLE:
  - start=1 at edge E0 is accepted.
  - Load shift register {bcd_in, BIN_W'b0}; counter=0; state←CONV.
  - start=0: remain IDLE.
- CONV (busy=1):
  - Each edge: right-shift the whole {bcd, bin} register by 1, MSB fill 0.
  - Then, per digit, if the digit is 8 or more, subtract 3 (4-bit, combinational after shift); counter+1.
  - After BIN_W iterations (edge E_BIN_W): bin_out←bin field; err←0; state←DONE.
- DONE (busy=0, done=1 for exactly one cycle): next edge state←IDLE, done←0.
- Latency: start edge to done-high = BIN_W+1 edges (done high during the cycle following E_BIN_W). Minimum start-to-start spacing = BIN_W+2 cycles.
- start while in CONV or DONE: ignored, no queuing, no effect on the current result.
- bcd_in is sampled only at the accept edge; later changes have no effect.
- bin_out and err change only on the DONE-entry edge or on reset; they are stable otherwise.
- Width rules:
  - Result is exact for all valid inputs 0 to 10^NUM_DIGITS-1.
  - With defaults, the max is 999 = 10'h3E7; no overflow possible when the parameter constraint holds.
- Invalid digits (nibble above 9): behaviour per Optional Feature.

Optional Feature:
Macro: BCD_TO_BIN_CHECK_EN
- Defined:
  - At the accept edge, any digit of bcd_in above 9 skips CONV: state←DONE directly, err←1, bin_out←0.
  - done is high the cycle after the start edge; busy never asserts.
- Not defined:
  - No validity check; invalid digits are converted by the same algorithm, result unspecified but deterministic.
  - err is tied to 0.

Test Plan:
1. Reset, then start with bcd_in=12'h999 → busy high 10 cycles; done pulses 11 edges after start; bin_out=10'h3E7; err=0.
2. bcd_in=12'h000, then 12'h255, then 12'h001 back-to-back (each start issued on first IDLE cycle) → bin_out=0, 10'h0FF, 10'h001 respectively; done pulses exactly once each.
3. Start with 12'h512; pulse start again at cycles 3 and 10 of CONV and change bcd_in to 12'h777 → single done; bin_out=10'h200; the extra starts are ignored.
4. Start with 12'h640; assert reset at cycle 5 of CONV → busy, done, bin_out, err all 0 immediately (async); no done pulse afterwards. A fresh start with 12'h640 then gives 10'h280.
5. With BCD_TO_BIN_CHECK_EN: start with 12'h1A5 → done the cycle after start; busy stays 0; err=1; bin_out=0. A following start with 12'h105 gives err=0, bin_out=10'h069.
6. Exhaustive sweep of 0–999, each value compared against the integer reference after every done; hold start high continuously → exactly one conversion per BIN_W+2 cycles.
